// File: rtl/alu_out_multi_collector.sv
// Multi-channel ALU result collector.
// Each channel's done/result strobe is latched into a holding register. A
// round-robin arbiter then moves one held result per cycle into a shared FIFO,
// tagged with its channel number. A strobe that arrives while its channel is
// still holding an ungranted value is dropped, and a sticky overflow bit records
// the loss.
module alu_out_multi_collector #(
   parameter  int RESULT_WIDTH = 16,
   parameter  int NUM_CH       = 2,
   parameter  int DEPTH        = 4,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W        = $clog2(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              done,
   input  logic [NUM_CH*RESULT_WIDTH-1:0] result,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [RESULT_WIDTH-1:0]        out_result,
   output logic [CH_W-1:0]                out_ch,
   output logic [CNT_W-1:0]               count,
   output logic [NUM_CH-1:0]              overflow,
   input  logic                           clr_ovf
);

   localparam int               AW   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [NUM_CH-1:0]       pend_q, pend_d, ovf_q, ovf_d, gnt, drop;
   logic [RESULT_WIDTH-1:0] hold_q [NUM_CH];
   logic [CH_W-1:0]         rr_q, rr_d, gnt_idx;
   logic                    gnt_vld, arb_en, pop, push;
   logic [RESULT_WIDTH-1:0] mem_res [DEPTH];
   logic [CH_W-1:0]         mem_ch  [DEPTH];
   logic [AW-1:0]           wr_q, rd_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   // A full FIFO can still accept a push in the cycle that it pops.
   assign pop    = (cnt_q != '0) && out_ready;
   assign arb_en = (cnt_q != FULL) || pop;
   assign push   = gnt_vld;

   // Round-robin pick. The loop walks from the far end back toward rr_q, so the
   // last match it writes is the pending channel closest to rr_q.
   always_comb begin
      int k;
      k       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         k = (int'(rr_q) + i) % NUM_CH;
         if (arb_en && pend_q[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = CH_W'(k);
         end
      end
   end

   // Per-channel grant decode, drop detection and pending-flag update.
   always_comb begin
      pend_d = pend_q;
      gnt    = '0;
      drop   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         gnt[c]  = gnt_vld && (gnt_idx == CH_W'(c));
         drop[c] = done[c] && pend_q[c] && !gnt[c];
         if (done[c] && (!pend_q[c] || gnt[c]))
            pend_d[c] = 1'b1;
         else if (gnt[c])
            pend_d[c] = 1'b0;
      end
   end

   // Overflow is sticky. A drop in the same cycle as clr_ovf sets the bit.
   assign ovf_d = (clr_ovf ? '0 : ovf_q) | drop;

   // Advance the round-robin pointer past the winner, wrapping at NUM_CH.
   always_comb begin
      rr_d = rr_q;
      if (gnt_vld)
         rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
   end

   // Occupancy. Push and pop together leave the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state and holding registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         ovf_q  <= '0;
         rr_q   <= '0;
         cnt_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         rr_q   <= rr_d;
         cnt_q  <= cnt_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         for (int c = 0; c < NUM_CH; c++)
            if (done[c] && (!pend_q[c] || gnt[c]))
               hold_q[c] <= result[c*RESULT_WIDTH +: RESULT_WIDTH];
      end
   end

   // FIFO storage. The granted channel's old held value is queued; a value
   // captured in the same cycle only replaces the holding register.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_res[wr_q] <= hold_q[gnt_idx];
         mem_ch[wr_q]  <= gnt_idx;
      end
   end

   // The head fields are gated so that they read zero while the FIFO is empty.
   assign out_valid  = (cnt_q != '0);
   assign out_result = out_valid ? mem_res[rd_q] : '0;
   assign out_ch     = out_valid ? mem_ch[rd_q]  : '0;
   assign count      = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_alu_out_multi_collector.sv
// Directed bench for alu_out_multi_collector (2 channels, 16-bit results, depth 4).
module tb_alu_out_multi_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  done;
   logic [31:0] result;
   logic        out_valid, out_ready;
   logic [15:0] out_result;
   logic [0:0]  out_ch;
   logic [2:0]  count;
   logic [1:0]  overflow;
   logic        clr_ovf;

   int errors = 0;
   int checks = 0;

   alu_out_multi_collector #(.RESULT_WIDTH(16), .NUM_CH(2), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .done(done), .result(result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_ch(out_ch), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  d;
      logic [15:0] r0, r1;
      logic        rdy;
      logic        v;
      logic [15:0] res;
      logic        ch;
      logic [2:0]  cnt;
      logic [1:0]  ovf;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe one channel for one cycle, then leave one idle cycle.
   task automatic strobe(input int c, input logic [15:0] val);
      done        = 2'b00;
      done[c]     = 1'b1;
      result      = 32'h0;
      result[c*16 +: 16] = val;
      tick();
      done = 2'b00;
      tick();
   endtask

   initial begin
      // Rows: inputs for one cycle, then the expected state after that edge.
      tbl[0]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[1]  = '{2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd1, 2'b00};
      tbl[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[4]  = '{2'b10, 16'h0000, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[5]  = '{2'b10, 16'h0000, 16'h2222, 1'b1, 1'b1, 16'h1111, 1'b1, 3'd1, 2'b00};
      tbl[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 1'b1, 3'd1, 2'b00};
      tbl[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[8]  = '{2'b11, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hAAAA, 1'b0, 3'd1, 2'b00};
      tbl[10] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBBBB, 1'b1, 3'd1, 2'b00};
      tbl[11] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[12] = '{2'b01, 16'h0C0C, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};
      tbl[13] = '{2'b11, 16'hCCCC, 16'hDDDD, 1'b1, 1'b1, 16'h0C0C, 1'b0, 3'd1, 2'b00};
      tbl[14] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hDDDD, 1'b1, 3'd1, 2'b00};
      tbl[15] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hCCCC, 1'b0, 3'd1, 2'b00};
      tbl[16] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 2'b00};

      rst = 1'b1; done = 2'b00; result = 32'h0; out_ready = 1'b0; clr_ovf = 1'b0;
      #1;
      chk("reset valid",    32'(out_valid),  0);
      chk("reset count",    32'(count),      0);
      chk("reset result",   32'(out_result), 0);
      chk("reset ch",       32'(out_ch),     0);
      chk("reset overflow", 32'(overflow),   0);
      tick(); tick();
      rst = 1'b0;

      // Single, back-to-back and simultaneous strobes with out_ready held high.
      for (int i = 0; i < 17; i++) begin
         done      = tbl[i].d;
         result    = {tbl[i].r1, tbl[i].r0};
         out_ready = tbl[i].rdy;
         tick();
         chk($sformatf("row%0d valid", i),    32'(out_valid),  32'(tbl[i].v));
         chk($sformatf("row%0d result", i),   32'(out_result), 32'(tbl[i].res));
         chk($sformatf("row%0d ch", i),       32'(out_ch),     32'(tbl[i].ch));
         chk($sformatf("row%0d count", i),    32'(count),      32'(tbl[i].cnt));
         chk($sformatf("row%0d overflow", i), 32'(overflow),   32'(tbl[i].ovf));
      end
      done = 2'b00;

      // Fill: six ch0 strobes with the consumer stalled.
      rst = 1'b1; #2; rst = 1'b0;
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) strobe(0, 16'(k));
      chk("full count",    32'(count),      4);
      chk("full overflow", 32'(overflow),   32'h1);
      chk("full head",     32'(out_result), 1);
      chk("full valid",    32'(out_valid),  1);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      chk("clr overflow", 32'(overflow), 0);

      // Release the consumer. The first pop lets the held entry 5 in during the
      // same cycle, so the FIFO stays full.
      out_ready = 1'b1;
      chk("pop1 value", 32'(out_result), 1);
      tick();
      chk("pushpop count",    32'(count),    4);
      chk("pushpop overflow", 32'(overflow), 0);
      for (int k = 2; k <= 5; k++) begin
         chk($sformatf("pop%0d value", k), 32'(out_result), k);
         chk($sformatf("pop%0d ch", k),    32'(out_ch),     0);
         tick();
      end
      chk("drain count", 32'(count),     0);
      chk("drain valid", 32'(out_valid), 0);

      // Reset while three entries are queued.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) strobe(0, 16'h0100 + 16'(k));
      chk("pre-reset count", 32'(count), 3);
      #2 rst = 1'b1;
      #1;
      chk("mid-reset valid",  32'(out_valid),  0);
      chk("mid-reset count",  32'(count),      0);
      chk("mid-reset result", 32'(out_result), 0);
      tick();
      rst = 1'b0;
      tick();
      chk("post-reset valid", 32'(out_valid), 0);

      // A drop in the same cycle as clr_ovf keeps the overflow bit set.
      done = 2'b11; result = {16'h6666, 16'h5555};
      tick();
      done = 2'b10; result = {16'h7777, 16'h0000}; clr_ovf = 1'b1;
      tick();
      done = 2'b00; clr_ovf = 1'b0;
      chk("clr+drop overflow", 32'(overflow), 32'h2);
      chk("clr+drop count",    32'(count),    1);
      tick();
      chk("clr+drop count2", 32'(count), 2);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      chk("clr alone overflow", 32'(overflow), 0);
      out_ready = 1'b1;
      chk("ovf pop0 value", 32'(out_result), 32'h5555);
      chk("ovf pop0 ch",    32'(out_ch),     0);
      tick();
      chk("ovf pop1 value", 32'(out_result), 32'h6666);
      chk("ovf pop1 ch",    32'(out_ch),     1);
      tick();
      chk("ovf drain count", 32'(count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
